// File: rtl/if_win_pkg.sv
// rtl/if_win_pkg.sv - shared constants and state encoding for the 5x5 window generator.
package if_win_pkg;
  localparam int K     = 5;
  localparam int PIX_W = 8;
  localparam int PAD   = 2;
  localparam int WIN_W = K * K * PIX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;
endpackage

// File: rtl/if_line_buf.sv
// rtl/if_line_buf.sv - one grid-row delay line; output is the pixel one row above the input.
module if_line_buf
  import if_win_pkg::*;
#(
  parameter int DEPTH = 28
) (
  input  logic             clk,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);
  logic [PIX_W-1:0] taps [DEPTH];

  // No reset: every tap is rewritten during the fill rows before it can reach a window.
  always_ff @(posedge clk) begin
    if (en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];
endmodule

// File: rtl/if_window_gen.sv
// rtl/if_window_gen.sv - raster-stream 5x5 window generator feeding the PE IF1..IF25 bus.
// Define IF_WIN_ZERO_PAD_EN for "same" convolution with two-pixel internal zero borders.
module if_window_gen
  import if_win_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [WIN_W-1:0] win_data,
  output logic [15:0]      win_row,
  output logic [15:0]      win_col,
  output logic             frame_done,
  output logic             busy
);
`ifdef IF_WIN_ZERO_PAD_EN
  localparam int GW = IMG_W + 2 * PAD;
  localparam int GH = IMG_H + 2 * PAD;
`else
  localparam int GW = IMG_W;
  localparam int GH = IMG_H;
`endif
  localparam logic [15:0] GW16 = 16'(GW);
  localparam logic [15:0] GH16 = 16'(GH);
  localparam logic [15:0] KM1  = 16'(K - 1);
  localparam int ROW_W  = K * PIX_W;
  localparam int HIST_W = (K - 1) * PIX_W;

  state_t state, state_nx;
  logic [15:0] gr, gc;
  logic can_step, step, complete, pad;
  logic [PIX_W-1:0] pix;
  logic [PIX_W-1:0] tap   [K-1];
  logic [PIX_W-1:0] lb_in [K-1];
  logic [PIX_W-1:0] col   [K];
  // Only the four newest columns are kept; the oldest falls off on every shift.
  logic [K*HIST_W-1:0] win_hist;
  logic [WIN_W-1:0]    win_nx;

`ifdef IF_WIN_ZERO_PAD_EN
  assign pad = (gr < 16'(PAD)) || (gr >= 16'(IMG_H + PAD)) ||
               (gc < 16'(PAD)) || (gc >= 16'(IMG_W + PAD));
  assign pix = pad ? '0 : in_pix;
`else
  assign pad = 1'b0;
  assign pix = in_pix;
`endif

  assign can_step = ((state == FILL) || (state == RUN)) && (gr < GH16) &&
                    (!win_valid || win_ready);
  assign in_ready = can_step && !pad;
  assign step     = can_step && (pad || in_valid);
  assign complete = (gr >= KM1) && (gc >= KM1);

  assign lb_in[0] = pix;
  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    if (i > 0) begin : g_cascade
      assign lb_in[i] = tap[i-1];
    end
    if_line_buf #(.DEPTH(GW)) u_lb (
      .clk  (clk),
      .en   (step),
      .din  (lb_in[i]),
      .dout (tap[i])
    );
  end

  // Right-hand column, top row first: the deepest tap is four rows above the new pixel.
  always_comb begin
    for (int r = 0; r < K - 1; r++) col[r] = tap[K-2-r];
    col[K-1] = pix;
  end

  always_comb begin
    win_nx = '0;
    for (int r = 0; r < K; r++)
      win_nx[r*ROW_W +: ROW_W] = {col[r], win_hist[r*HIST_W +: HIST_W]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    frame_done = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: if (start) state_nx = FILL;
      FILL: if (gr == KM1) state_nx = RUN;
      RUN: begin
        if (win_valid && win_ready && (win_row == GH16 - 16'(K)) &&
            (win_col == GW16 - 16'(K))) begin
          frame_done = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gr        <= '0;
      gc        <= '0;
      win_hist  <= '0;
      win_valid <= 1'b0;
      win_data  <= '0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        gr <= '0;
        gc <= '0;
      end else if (step) begin
        for (int r = 0; r < K; r++)
          win_hist[r*HIST_W +: HIST_W] <= win_nx[r*ROW_W+PIX_W +: HIST_W];
        if (gc == GW16 - 16'd1) begin
          gc <= '0;
          gr <= gr + 16'd1;
        end else begin
          gc <= gc + 16'd1;
        end
      end
      if (step && complete) begin
        win_valid <= 1'b1;
        win_data  <= win_nx;
        win_row   <= gr - KM1;
        win_col   <= gc - KM1;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_if_window_gen.sv
// tb/tb_if_window_gen.sv - directed bench with a window-level model for if_window_gen (8x8 frames).
module tb_if_window_gen;
  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
`ifdef IF_WIN_ZERO_PAD_EN
  localparam int P = 2, OW = IMG_W, OH = IMG_H, OFS = 1;
`else
  localparam int P = 0, OW = IMG_W - 4, OH = IMG_H - 4, OFS = 0;
`endif
  localparam int NWIN = OW * OH;
  localparam int EXP_FRAMES = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] in_pix = 8'd0;
  logic win_valid;
  logic win_ready = 1'b1;
  logic [199:0] win_data;
  logic [15:0] win_row, win_col;
  logic frame_done, busy;

  int n_chk = 0, n_fail = 0;
  int idx = 0, frames = 0, timeouts = 0;
  logic finish_req = 1'b0;

  if_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_pix(in_pix), .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(int y, int x);
    return 8'((IMG_W * y + x + OFS) & 255);
  endfunction

  // Window idx in raster order of output positions, zeros outside the image.
  function automatic logic [199:0] exp_win(int n);
    logic [199:0] w;
    int wr, wc, y, x;
    wr = n / OW;
    wc = n % OW;
    w = '0;
    for (int k = 0; k < 25; k++) begin
      y = wr + k / 5 - P;
      x = wc + k % 5 - P;
      if (y >= 0 && y < IMG_H && x >= 0 && x < IMG_W) w[8*k +: 8] = pat(y, x);
    end
    return w;
  endfunction

  function automatic logic [7:0] ifk(logic [199:0] d, int n);
    return d[8*(n-1) +: 8];
  endfunction

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (window %0d)", name, act, exp, idx);
    end
  endtask

  initial begin : compare
    bit fd_exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_in_ready", 200'(in_ready), 200'(0));
        check("rst_win_valid", 200'(win_valid), 200'(0));
        check("rst_win_data", win_data, 200'(0));
        check("rst_win_row", 200'(win_row), 200'(0));
        check("rst_win_col", 200'(win_col), 200'(0));
        check("rst_frame_done", 200'(frame_done), 200'(0));
        check("rst_busy", 200'(busy), 200'(0));
        idx = 0;
      end else begin
        if (start && !busy) idx = 0;
        if (!busy) check("idle_in_ready", 200'(in_ready), 200'(0));
        if (win_valid) begin
          check("win_data", win_data, exp_win(idx));
          check("win_row", 200'(win_row), 200'(idx / OW));
          check("win_col", 200'(win_col), 200'(idx % OW));
          if (!win_ready) check("blocked_in_ready", 200'(in_ready), 200'(0));
        end
        fd_exp = win_valid && win_ready && (idx == NWIN - 1);
        check("frame_done", 200'(frame_done), 200'(fd_exp));
        if (win_valid && win_ready) begin
`ifdef IF_WIN_ZERO_PAD_EN
          if (idx == 0) begin
            check("first_if13", 200'(ifk(win_data, 13)), 200'(1));
            check("first_if14", 200'(ifk(win_data, 14)), 200'(2));
            check("first_if18", 200'(ifk(win_data, 18)), 200'(9));
            check("first_if25", 200'(ifk(win_data, 25)), 200'(19));
            check("first_if1_12", 200'(win_data[95:0]), 200'(0));
          end
          if (idx == NWIN - 1) begin
            check("last_if13", 200'(ifk(win_data, 13)), 200'(64));
            check("last_if19_25", 200'(win_data[199:144]), 200'(0));
          end
`else
          if (idx == 0) begin
            check("first_if1", 200'(ifk(win_data, 1)), 200'(0));
            check("first_if13", 200'(ifk(win_data, 13)), 200'(18));
            check("first_if25", 200'(ifk(win_data, 25)), 200'(36));
          end
          if (idx == NWIN - 1) check("last_if25", 200'(ifk(win_data, 25)), 200'(63));
`endif
          if (idx == NWIN - 1) frames++;
          idx++;
        end
      end
      if (finish_req) begin
        check("frames_completed", 200'(frames), 200'(EXP_FRAMES));
        check("timeouts", 200'(timeouts), 200'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  end

  task automatic run_frame(input bit toggle, input bit stall, input bit kick, input bit abort);
    int pix_n, hs_n, stall_left;
    bit stalled, kicked, phase, acc, hs, done;
    pix_n = 0; hs_n = 0; stall_left = 0;
    stalled = 0; kicked = 0; phase = 0; done = 0;
    @(posedge clk); #1;
    start = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (stall_left > 0) begin
        win_ready = 1'b0;
        stall_left--;
      end else begin
        win_ready = 1'b1;
      end
      phase = ~phase;
      in_valid = (pix_n < IMG_W * IMG_H) && (!toggle || phase);
      in_pix = pat(pix_n / IMG_W, pix_n % IMG_W);
      if (kick && !kicked && hs_n == 5) begin
        start = 1'b1;
        kicked = 1;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      hs = win_valid && win_ready;
      if (frame_done) done = 1;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) pix_n++;
      if (hs) hs_n++;
      if (stall && !stalled && hs_n == 2 && win_valid) begin
        stall_left = 5;
        stalled = 1;
      end
      if (abort && pix_n == 20) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        done = 1;
      end
    end
    if (!done) timeouts++;
    in_valid = 1'b0;
    win_ready = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin : driver
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    run_frame(0, 0, 0, 0);
    run_frame(0, 1, 0, 0);
    run_frame(1, 0, 0, 0);
    run_frame(0, 0, 0, 1);
    run_frame(0, 0, 0, 0);
    run_frame(0, 0, 1, 0);
    @(posedge clk); #1;
    finish_req = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL finish: compare process did not reach summary");
    $fatal(1);
  end
endmodule
